// File: rtl/axi_rd_arbiter_if.sv
// One AXI4 read channel (AR + R). The master modport issues AR and accepts R;
// the slave modport accepts AR and returns R.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arid;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arid, arvalid, rready,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arvalid, rready,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read arbiter: port 0 = I-cache, port 1 = D-cache, one burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin tie-break; otherwise port 1 wins ties.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_rd_arbiter_if.slave       s0_if,
  axi_rd_arbiter_if.slave       s1_if,
  axi_rd_arbiter_if.master      m_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_grant, w_grant_nxt;
  logic   w_tie_winner;
  logic   w_r_done;

  logic [ADDR_W-1:0] w_araddr [2];
  logic [7:0]        w_arlen  [2];
  logic [2:0]        w_arsize [2];
  logic [1:0]        w_arvalid;
  logic [1:0]        w_rready;
  logic [1:0]        w_arready;
  logic [1:0]        w_rvalid;

  logic [ADDR_W-1:0] w_m_araddr;
  logic [7:0]        w_m_arlen;
  logic [2:0]        w_m_arsize;
  logic              w_m_arvalid;
  logic              w_m_rready;

  assign w_araddr[0]  = s0_if.araddr;
  assign w_araddr[1]  = s1_if.araddr;
  assign w_arlen[0]   = s0_if.arlen;
  assign w_arlen[1]   = s1_if.arlen;
  assign w_arsize[0]  = s0_if.arsize;
  assign w_arsize[1]  = s1_if.arsize;
  assign w_arvalid    = {s1_if.arvalid, s0_if.arvalid};
  assign w_rready     = {s1_if.rready, s0_if.rready};

  assign w_r_done = (r_state == DATA) & m_if.rvalid & w_m_rready & m_if.rlast;

`ifdef AXI_RD_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst)           r_last <= 1'b0;
    else if (w_r_done) r_last <= r_grant;
  end

  assign w_tie_winner = ~r_last;
`else
  assign w_tie_winner = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous to match the rest of the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_arready   = '0;
    w_rvalid    = '0;
    w_m_araddr  = '0;
    w_m_arlen   = '0;
    w_m_arsize  = '0;
    w_m_arvalid = 1'b0;
    w_m_rready  = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_arvalid) begin
          w_state_nxt = ADDR;
          w_grant_nxt = (&w_arvalid) ? w_tie_winner : w_arvalid[1];
        end
      end
      ADDR: begin
        w_m_araddr           = w_araddr[r_grant];
        w_m_arlen            = w_arlen[r_grant];
        w_m_arsize           = w_arsize[r_grant];
        w_m_arvalid          = w_arvalid[r_grant];
        w_arready[r_grant]   = m_if.arready;
        if (w_m_arvalid && m_if.arready) w_state_nxt = DATA;
      end
      DATA: begin
        w_m_rready        = w_rready[r_grant];
        w_rvalid[r_grant] = m_if.rvalid;
        if (m_if.rvalid && w_m_rready && m_if.rlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign m_if.araddr  = w_m_araddr;
  assign m_if.arlen   = w_m_arlen;
  assign m_if.arsize  = w_m_arsize;
  assign m_if.arid    = r_grant;
  assign m_if.arvalid = w_m_arvalid;
  assign m_if.rready  = w_m_rready;

  // R data and last are broadcast; only rvalid selects the receiving cache.
  assign s0_if.arready = w_arready[0];
  assign s1_if.arready = w_arready[1];
  assign s0_if.rvalid  = w_rvalid[0];
  assign s1_if.rvalid  = w_rvalid[1];
  assign s0_if.rdata   = m_if.rdata;
  assign s1_if.rdata   = m_if.rdata;
  assign s0_if.rlast   = m_if.rlast;
  assign s1_if.rlast   = m_if.rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; expected tie-break follows AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .s0_if (s0_if),
    .s1_if (s1_if),
    .m_if  (m_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0; s0_if.arvalid = 1'b0;
    s0_if.rready = 1'b0; s0_if.arid = 1'b0;
    s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0; s1_if.arvalid = 1'b0;
    s1_if.rready = 1'b0; s1_if.arid = 1'b0;
    m_if.arready = 1'b0; m_if.rdata = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [7:0] l);
    if (p == 0) begin
      s0_if.araddr = a; s0_if.arlen = l; s0_if.arsize = 3'd2; s0_if.arvalid = 1'b1;
    end else begin
      s1_if.araddr = a; s1_if.arlen = l; s1_if.arsize = 3'd2; s1_if.arvalid = 1'b1;
    end
  endtask

  task automatic set_arvalid(input int p, input logic v);
    if (p == 0) s0_if.arvalid = v;
    else        s1_if.arvalid = v;
  endtask

  task automatic set_rready(input int p, input logic v);
    if (p == 0) s0_if.rready = v;
    else        s1_if.rready = v;
  endtask

  function automatic logic get_arready(input int p);
    return (p == 0) ? s0_if.arready : s1_if.arready;
  endfunction

  function automatic logic get_rvalid(input int p);
    return (p == 0) ? s0_if.rvalid : s1_if.rvalid;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {58'd0, m_if.arvalid, m_if.rready, s0_if.arready,
                           s1_if.arready, s0_if.rvalid, s1_if.rvalid}, 64'd0);
    check({tag, "_araddr"}, {32'd0, m_if.araddr}, 64'd0);
    check({tag, "_arid"}, {63'd0, m_if.arid}, 64'd0);
  endtask

  // Called on the first ADDR cycle: checks the forwarded AR, stalls it, then
  // streams len+1 beats while checking routing, and ends on the IDLE bubble cycle.
  task automatic serve(input int p, input logic [31:0] addr, input logic [7:0] len,
                       input logic [31:0] dbase, input int ar_stall, input bit toggle);
    int   q    = 1 - p;
    int   beat = 0;
    int   cyc  = 0;
    logic rr;
    check($sformatf("p%0d_arvalid", p), {63'd0, m_if.arvalid}, 64'd1);
    check($sformatf("p%0d_arid", p), {63'd0, m_if.arid}, p);
    check($sformatf("p%0d_araddr", p), {32'd0, m_if.araddr}, {32'd0, addr});
    check($sformatf("p%0d_arlen", p), {56'd0, m_if.arlen}, {56'd0, len});
    m_if.arready = 1'b0;
    for (int i = 0; i < ar_stall; i++) begin
      settle();
      check("stall_arready", {63'd0, get_arready(p)}, 64'd0);
      check("stall_araddr", {32'd0, m_if.araddr}, {32'd0, addr});
      check("stall_arvalid", {63'd0, m_if.arvalid}, 64'd1);
      tick();
    end
    m_if.arready = 1'b1;
    settle();
    check("arready_grant", {63'd0, get_arready(p)}, 64'd1);
    check("arready_other", {63'd0, get_arready(q)}, 64'd0);
    tick();
    m_if.arready = 1'b0;
    set_arvalid(p, 1'b0);
    while (beat <= int'(len) && cyc < 2 * int'(len) + 8) begin
      rr = toggle ? ((cyc % 2) == 0) : 1'b1;
      m_if.rvalid = 1'b1;
      m_if.rdata  = dbase + beat;
      m_if.rlast  = (beat == int'(len));
      set_rready(p, rr);
      settle();
      check("rvalid_grant", {63'd0, get_rvalid(p)}, 64'd1);
      check("rvalid_other", {63'd0, get_rvalid(q)}, 64'd0);
      check("m_rready", {63'd0, m_if.rready}, {63'd0, rr});
      if (rr) begin
        check("rdata", {32'd0, (p == 0) ? s0_if.rdata : s1_if.rdata}, {32'd0, dbase + beat});
        check("rlast", {63'd0, s0_if.rlast}, (beat == int'(len)) ? 64'd1 : 64'd0);
      end
      tick();
      if (rr) beat++;
      cyc++;
    end
    check("beats_delivered", beat, int'(len) + 1);
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    set_rready(p, 1'b0);
    settle();
    check("bubble_arvalid", {63'd0, m_if.arvalid}, 64'd0);
    check("bubble_rvalid", {62'd0, s1_if.rvalid, s0_if.rvalid}, 64'd0);
    exp_last = p[0];
  endtask

  function automatic int tie_winner();
`ifdef AXI_RD_ARB_RR_EN
    return exp_last ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic tie_round(input logic [31:0] base);
    int w;
    set_req(0, base, 8'd3);
    set_req(1, base + 32'h100, 8'd3);
    tick();
    w = tie_winner();
    serve(w, (w == 0) ? base : base + 32'h100, 8'd3, base, 0, 1'b0);
    tick();
    serve(1 - w, (w == 0) ? base + 32'h100 : base, 8'd3, base + 32'h10, 0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
    exp_last = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    settle();
    check_idle("reset");
    check("reset_arlen", {56'd0, m_if.arlen}, 64'd0);

    // Single port-0 burst of 8 beats; m_arvalid one cycle after the request.
    set_req(0, 32'h1FC0_0000, 8'd7);
    settle();
    check("ar_latency_n", {63'd0, m_if.arvalid}, 64'd0);
    tick();
    serve(0, 32'h1FC0_0000, 8'd7, 32'hA000_0000, 0, 1'b0);
    tick();

    // Ties from reset: port 1 then 0, three times, in either arbitration mode.
    do_reset();
    for (int r = 0; r < 3; r++) tie_round(32'h1000 + r * 32'h1000);

    // Single-beat request from port 1.
    set_req(1, 32'h3000, 8'd0);
    tick();
    serve(1, 32'h3000, 8'd0, 32'hC000_0000, 0, 1'b0);
    tick();

    // Tie after port 1 finished last: round-robin now favours port 0.
    tie_round(32'h8000);

    // AR back-pressure for 5 cycles and R back-pressure every other cycle.
    set_req(0, 32'h4000, 8'd7);
    tick();
    serve(0, 32'h4000, 8'd7, 32'hD000_0000, 5, 1'b1);
    tick();

    // Reset during beat 3 of an 8-beat burst.
    set_req(0, 32'h5000, 8'd7);
    tick();
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    set_arvalid(0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      m_if.rvalid = 1'b1;
      m_if.rdata  = 32'hF000 + b;
      s0_if.rready = 1'b1;
      if (b == 3) rst = 1'b1;
      settle();
      check("pre_rst_rvalid", {63'd0, s0_if.rvalid}, 64'd1);
      tick();
    end
    check_idle("mid_rst");
    rst = 1'b0;
    clear_inputs();
    exp_last = 1'b0;
    settle();
    check_idle("post_rst");
    set_req(0, 32'h6000, 8'd1);
    tick();
    serve(0, 32'h6000, 8'd1, 32'hE000_0000, 0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
